// File: rtl/riscv_pkg.sv
// Shared RiscV pipeline definitions: bus width defaults, memory-arbiter FSM states and grant encoding.
package riscv_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned MEM_LAT_DEF = 1;
    localparam int unsigned FAIR_N_DEF  = 4;
    localparam int unsigned LAT_W       = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } grant_e;

endpackage

// File: rtl/arb_fair_pick.sv
// Combinational grant pick: data first, fetch forced once data has won FAIR_N times in a row.
module arb_fair_pick
    import riscv_pkg::*;
#(
    parameter int unsigned FAIR_N = FAIR_N_DEF,
    parameter int unsigned CNT_W  = 3
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] fair_cnt,
    output grant_e           grant_c
);

    always_comb begin
        grant_c = GNT_NONE;
        if (if_req && (fair_cnt == CNT_W'(FAIR_N))) begin
            grant_c = GNT_IF;
        end else if (d_req) begin
            grant_c = GNT_D;
        end else if (if_req) begin
            grant_c = GNT_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between the IF (fetch) and MEM (load/store) stages.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MEM_LAT = MEM_LAT_DEF,
    parameter int unsigned FAIR_N  = FAIR_N_DEF
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_d
);

    localparam int unsigned CNT_W = $clog2(FAIR_N + 1);

    if ((MEM_LAT < 1) || (MEM_LAT > 7)) begin : g_lat_range
        $error("mem_port_arbiter: MEM_LAT must be within 1..7");
    end

    arb_state_e        state_q, state_d;
    grant_e            grant_q, grant_d, pick_c;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [CNT_W-1:0]  fair_q, fair_d;
    logic              acc_we_q, acc_we_d;
    logic              mem_en_d, mem_we_d, if_ack_d, d_ack_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, d_rdata_d;

    arb_fair_pick #(
        .FAIR_N (FAIR_N),
        .CNT_W  (CNT_W)
    ) u_pick (
        .if_req   (if_req),
        .d_req    (d_req),
        .fair_cnt (fair_q),
        .grant_c  (pick_c)
    );

    assign stall_if = if_req & ~if_ack;
    assign stall_d  = d_req & ~d_ack;

    // Next-state and next-register values; the issue cycle does not count toward latency.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lat_d       = lat_q;
        acc_we_d    = acc_we_q;
        fair_d      = fair_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;

        if (!if_req) begin
            fair_d = '0;
        end else if ((state_q == IDLE) && (pick_c == GNT_IF)) begin
            fair_d = '0;
        end else if ((state_q == IDLE) && (pick_c == GNT_D) && (fair_q < CNT_W'(FAIR_N))) begin
            fair_d = fair_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                grant_d = pick_c;
                if (pick_c == GNT_IF) begin
                    state_d    = ACCESS;
                    lat_d      = LAT_W'(MEM_LAT);
                    acc_we_d   = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = if_addr;
                end else if (pick_c == GNT_D) begin
                    state_d     = ACCESS;
                    lat_d       = LAT_W'(MEM_LAT);
                    acc_we_d    = d_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end
            end
            ACCESS: begin
                if (!mem_en) begin
                    if (lat_q == LAT_W'(1)) begin
                        state_d = RESP;
                        if (grant_q == GNT_IF) begin
                            if_rdata_d = mem_rdata;
                            if_ack_d   = 1'b1;
                        end else begin
                            if (!acc_we_q) begin
                                d_rdata_d = mem_rdata;
                            end
                            d_ack_d = 1'b1;
                        end
                    end else begin
                        lat_d = lat_q - LAT_W'(1);
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= IDLE;
            grant_q   <= GNT_NONE;
            lat_q     <= '0;
            fair_q    <= '0;
            acc_we_q  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            lat_q     <= lat_d;
            fair_q    <= fair_d;
            acc_we_q  <= acc_we_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_ack    <= if_ack_d;
            d_ack     <= d_ack_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
        end
    end

endmodule
